tmds_link_sequencer: RTL

//  Brings up and supervises the TMDS output link in the pixel_clk domain.
//  - Holds every TMDS serializer (3 data channels + clock channel) in reset until the PLL/MMCM lock is stable.
//  - Forces encoders to emit blanking/control symbols while the serializers settle.
//  - Releases video only on a frame boundary.
//  - Tears the link down and re-sequences on lock loss or on a restart request.

---
 rtl/tmds_pkg.sv | 30 +++
 rtl/bit_synchronizer.sv | 25 ++
 rtl/tmds_link_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS link definitions: link sequencer states and the DVI/HDMI
// control-period symbols that encoders emit while video is blanked.
package tmds_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    RESET      = 3'd1,
    SETTLE     = 3'd2,
    WAIT_FRAME = 3'd3,
    ACTIVE     = 3'd4
  } link_state_e;

  // 10-bit control symbols indexed by {c1, c0}.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic logic [9:0] tmds_ctrl_symbol(input logic c1, input logic c0);
    logic [9:0] sym;
    case ({c1, c0})
      2'b00:   sym = TMDS_CTRL_00;
      2'b01:   sym = TMDS_CTRL_01;
      2'b10:   sym = TMDS_CTRL_10;
      default: sym = TMDS_CTRL_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level into clk.
// Resets to 0 so a not-yet-synchronized input always reads as deasserted.
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/tmds_link_sequencer.sv
// TMDS link bring-up sequencer: qualifies PLL lock, holds the serializers
// in reset, forces blanking while they settle, opens video on a frame
// boundary, and tears the link down on lock loss or restart.
module tmds_link_sequencer
  import tmds_pkg::*;
#(
  parameter int LOCK_FILTER   = 8,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  input  logic       frame_start,
  output logic       serdes_rst,
  output logic       force_blank,
  output logic       enc_enable,
  output logic       link_up,
  output logic [7:0] relock_count
);

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LF_W    = $clog2(LOCK_FILTER + 1);

  // The WAIT_LOCK cycle in which lock_ok is seen already holds serdes_rst,
  // so RESET itself lasts one cycle less than RST_CYCLES.
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 2);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LF_W-1:0]  LF_LAST     = LF_W'(LOCK_FILTER - 1);

  logic              locked_s;
  logic [LF_W-1:0]   lock_cnt_reg;
  logic              lock_ok_reg;
  logic              lock_ok;
  link_state_e       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              lock_loss;
  logic              serdes_rst_reg, force_blank_reg, enc_enable_reg, link_up_reg;
  logic [7:0]        relock_count_reg;

  bit_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (pixel_clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Lock qualification: count consecutive locked cycles, drop on any gap.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_reg <= '0;
      lock_ok_reg  <= 1'b0;
    end else if (!locked_s) begin
      lock_cnt_reg <= '0;
      lock_ok_reg  <= 1'b0;
    end else if (!lock_ok_reg) begin
      if (lock_cnt_reg == LF_LAST) begin
        lock_ok_reg <= 1'b1;
      end else begin
        lock_cnt_reg <= lock_cnt_reg + LF_W'(1);
      end
    end
  end

  // A deasserted synchronized lock kills lock_ok in the same cycle.
  assign lock_ok = lock_ok_reg & locked_s;

  // Next-state and cycle-counter logic; lock loss beats restart beats normal flow.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lock_loss  = 1'b0;
    case (state_reg)
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_next = RESET;
          cnt_next   = RST_LOAD;
        end
      end
      RESET: begin
        if (cnt_reg == '0) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_reg == '0) begin
          state_next = WAIT_FRAME;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      WAIT_FRAME: begin
        if (frame_start) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        state_next = ACTIVE;
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
    if (state_reg inside {RESET, SETTLE, WAIT_FRAME, ACTIVE}) begin
      if (!locked_s) begin
        lock_loss  = 1'b1;
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end else if (restart && lock_ok) begin
        state_next = RESET;
        cnt_next   = RST_LOAD;
      end
    end
  end

  // State, counter, lock-loss tally and outputs decoded from the next state.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= WAIT_LOCK;
      cnt_reg          <= '0;
      relock_count_reg <= 8'd0;
      serdes_rst_reg   <= 1'b1;
      force_blank_reg  <= 1'b1;
      enc_enable_reg   <= 1'b0;
      link_up_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (lock_loss && (relock_count_reg != 8'hFF)) begin
        relock_count_reg <= relock_count_reg + 8'd1;
      end
      serdes_rst_reg  <= (state_next == WAIT_LOCK) || (state_next == RESET);
      force_blank_reg <= (state_next != ACTIVE);
      enc_enable_reg  <= (state_next == ACTIVE);
      link_up_reg     <= (state_next == ACTIVE);
    end
  end

  assign serdes_rst   = serdes_rst_reg;
  assign force_blank  = force_blank_reg;
  assign enc_enable   = enc_enable_reg;
  assign link_up      = link_up_reg;
  assign relock_count = relock_count_reg;

endmodule
